// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-MODULUS up/down counter. Every state bit changes only through its J/K pair.
// Optional macro JK_MOD_COUNTER_SAT_EN: saturate at the range ends instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             TC,
  output logic             Wrap
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] toggle_up, toggle_dn, toggle;
  logic [WIDTH-1:0] load_sat;
  logic             at_max, at_zero;

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic [WIDTH-1:0] mask;
    mask      = '0;
    toggle_up = '0;
    toggle_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask         = WIDTH'((1 << i) - 1);
      toggle_up[i] = ((q_q & mask) == mask);
      toggle_dn[i] = ((q_q & mask) == '0);
    end
  end

  assign toggle   = Up ? toggle_up : toggle_dn;
  assign at_max   = (q_q == MAX_VAL);
  assign at_zero  = (q_q == '0);
  assign load_sat = ({1'b0, Load_val} >= MOD_EXT) ? MAX_VAL : Load_val;
  assign TC       = En & ((Up & at_max) | (~Up & at_zero));

  always_comb begin
    j_vec  = '0;
    k_vec  = '0;
    wrap_d = 1'b0;
    if (Clear) begin
      k_vec = '1;
    end else if (Load) begin
      j_vec = load_sat;
      k_vec = ~load_sat;
    end else if (En) begin
      if (TC) begin
`ifdef JK_MOD_COUNTER_SAT_EN
        // boundary reached: J=K=0 holds the value, no wrap pulse
        wrap_d = 1'b0;
`else
        wrap_d = 1'b1;
        if (Up) begin
          k_vec = '1;
        end else begin
          j_vec = MAX_VAL;
          k_vec = ~MAX_VAL;
        end
`endif
      end else begin
        j_vec = toggle;
        k_vec = toggle;
      end
    end
  end

  assign q_d = (j_vec & ~q_q) | (~k_vec & q_q);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;
  assign Wrap  = wrap_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter (WIDTH=4, MODULUS=10): vector table driven through a scoreboard queue,
// plus hand-written reset sequences. Expectations follow JK_MOD_COUNTER_SAT_EN when defined.
module tb_jk_mod_counter;

`ifdef JK_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       CLK, Reset, Clear, En, Up, Load;
  logic [3:0] Load_val, Q, Q_bar;
  logic       TC, Wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       clr, ld, en, up;
    logic [3:0] lv;
    logic       tc;
    logic [3:0] q;
    logic       wrap;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] q;
    logic       wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK(CLK), .Reset(Reset), .Clear(Clear), .En(En), .Up(Up), .Load(Load),
    .Load_val(Load_val), .Q(Q), .Q_bar(Q_bar), .TC(TC), .Wrap(Wrap)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic clr, input logic ld, input logic en, input logic up,
                              input logic [3:0] lv, input logic tc, input logic [3:0] q,
                              input logic wrap);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.up = up; v.lv = lv;
    v.tc = tc; v.q = q; v.wrap = wrap;
    vecs.push_back(v);
  endfunction

  // Invariants sampled away from the active edge.
  always @(negedge CLK) begin
    logic [3:0] nq;
    nq = ~Q;
    chk("qbar_inv", Q_bar, nq);
    chk("q_range", (Q < 4'd10), 1);
  end

  // Scoreboard consumer: one expected record per driven edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("q[%0d]", e.idx), Q, e.q);
        chk($sformatf("wrap[%0d]", e.idx), Wrap, e.wrap);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] q, pre, post;
    logic       w;

    Reset = 1'b0; Clear = 1'b0; En = 1'b0; Up = 1'b0; Load = 1'b0; Load_val = 4'd0;

    // count up 12 edges from 0
    q = 4'd0;
    for (int i = 0; i < 12; i++) begin
      pre = q;
      if (pre == 4'd9) begin
        post = SAT ? 4'd9 : 4'd0;
        w    = !SAT;
      end else begin
        post = pre + 4'd1;
        w    = 1'b0;
      end
      add(0, 0, 1, 1, 4'd0, (pre == 4'd9), post, w);
      q = post;
    end
    add(1, 0, 1, 1, 4'd0, (q == 4'd9), 4'd0, 0);
    // down from 0
    add(0, 0, 1, 0, 4'd0, 1, SAT ? 4'd0 : 4'd9, !SAT);
    add(0, 0, 1, 0, 4'd0, SAT, SAT ? 4'd0 : 4'd8, 0);
    add(0, 0, 1, 0, 4'd0, SAT, SAT ? 4'd0 : 4'd7, 0);
    add(0, 1, 0, 0, 4'd7, 0, 4'd7, 0);
    // hold at 7 with Up toggling
    for (int i = 0; i < 5; i++) add(0, 0, 0, (i % 2 == 0), 4'd0, 0, 4'd7, 0);
    // loads, clamping, priority
    add(0, 1, 1, 1, 4'd6,  0, 4'd6, 0);
    add(0, 1, 1, 1, 4'd13, 0, 4'd9, 0);
    add(0, 1, 1, 1, 4'd15, 1, 4'd9, 0);
    add(1, 1, 1, 1, 4'd5,  1, 4'd0, 0);
    add(0, 1, 0, 1, 4'd10, 0, 4'd9, 0);
    add(0, 1, 0, 1, 4'd0,  0, 4'd0, 0);
    add(0, 1, 0, 0, 4'd1,  0, 4'd1, 0);
    add(0, 0, 1, 0, 4'd0,  0, 4'd0, 0);
    add(0, 0, 1, 0, 4'd0,  1, SAT ? 4'd0 : 4'd9, !SAT);
    add(1, 0, 0, 0, 4'd0,  0, 4'd0, 0);
    add(0, 1, 0, 1, 4'd5,  0, 4'd5, 0);
    add(0, 0, 1, 1, 4'd0,  0, 4'd6, 0);

    #1;
    chk("rst_q", Q, 4'd0);
    chk("rst_qbar", Q_bar, 4'hF);
    chk("rst_wrap", Wrap, 1'b0);
    #14 Reset = 1'b1;

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge CLK);
      Clear = vecs[i].clr; Load = vecs[i].ld; En = vecs[i].en;
      Up = vecs[i].up; Load_val = vecs[i].lv;
      #1;
      chk($sformatf("tc[%0d]", i), TC, vecs[i].tc);
      e.idx = i; e.q = vecs[i].q; e.wrap = vecs[i].wrap;
      sb.push_back(e);
    end
    @(posedge CLK);
    #2;
    chk("sb_drained", sb.size(), 0);

    // reset between edges while counting up from 6
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_q", Q, 4'd0);
    chk("midrst_qbar", Q_bar, 4'hF);
    chk("midrst_wrap", Wrap, 1'b0);
    @(posedge CLK);
    #1;
    chk("midrst_hold", Q, 4'd0);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("resume_q1", Q, 4'd1);
    @(posedge CLK);
    #1;
    chk("resume_q2", Q, 4'd2);
    @(negedge CLK);
    En = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
